e_muldiv_unit: RTL

- Execute-stage multiply/divide unit with HI/LO registers.
- Consumes the control and operand outputs of the D->E pipeline register: md_op_E, RD1_E, RD2_E.
- Models multi-cycle mult/div latency with a busy counter. Exposes busy/start so the hazard unit can stall D and assert the E-stage clear.
- Serves mfhi/mflo/mthi/mtlo.

---
 rtl/md_pkg.sv | 44 ++++
 rtl/e_muldiv_unit.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the E-stage multiply/divide unit and the hazard unit:
// op encodings, default latencies and the decode predicates.
package md_pkg;

    typedef enum logic [3:0] {
        MdNone  = 4'd0,
        MdMult  = 4'd1,
        MdMultu = 4'd2,
        MdDiv   = 4'd3,
        MdDivu  = 4'd4,
        MdMthi  = 4'd5,
        MdMtlo  = 4'd6,
        MdMfhi  = 4'd7,
        MdMflo  = 4'd8
    } md_op_e;

    typedef enum logic {
        StIdle,
        StBusy
    } md_state_e;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } md_result_t;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    // Ops that launch a multi-cycle operation when the unit is idle.
    function automatic logic is_md_start(input logic [3:0] op);
        return (op == MdMult) || (op == MdMultu) || (op == MdDiv) || (op == MdDivu);
    endfunction

    function automatic logic is_md_div(input logic [3:0] op);
        return (op == MdDiv) || (op == MdDivu);
    endfunction

    // Any op that touches HI/LO; the hazard unit stalls these while start|busy.
    function automatic logic is_md_class(input logic [3:0] op);
        return (op >= MdMult) && (op <= MdMflo);
    endfunction

endpackage

// File: rtl/e_muldiv_unit.sv
// Execute-stage multiply/divide unit with HI/LO registers and a latency counter.
// Optional MD_DIV0_FLAG_EN adds a sticky divide-by-zero flag output.
module e_muldiv_unit
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  md_op_E,
    input  logic [31:0] RD1_E,
    input  logic [31:0] RD2_E,
    output logic        start,
    output logic        busy,
    output logic [31:0] md_rdata_E,
    output logic [31:0] hi_q,
    output logic [31:0] lo_q
`ifdef MD_DIV0_FLAG_EN
    ,
    output logic        div0_sticky
`endif
);

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    md_state_e   state_q;
    logic        busy_q;
    logic [3:0]  cnt_q;
    logic [31:0] pend_hi_q;
    logic [31:0] pend_lo_q;

    logic        is_signed;
    logic        a_neg;
    logic        b_neg;
    logic        div_zero;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] prod;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] safe_b;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;
    md_result_t  res;

    // Division runs on magnitudes so INT_MIN / -1 wraps to INT_MIN without overflow.
    always_comb begin
        is_signed = (md_op_E == MdMult) || (md_op_E == MdDiv);
        a_neg     = is_signed & RD1_E[31];
        b_neg     = is_signed & RD2_E[31];
        div_zero  = (RD2_E == 32'd0);

        ext_a = {{32{a_neg}}, RD1_E};
        ext_b = {{32{b_neg}}, RD2_E};
        prod  = ext_a * ext_b;

        abs_a  = a_neg ? (~RD1_E + 32'd1) : RD1_E;
        abs_b  = b_neg ? (~RD2_E + 32'd1) : RD2_E;
        safe_b = div_zero ? 32'd1 : abs_b;
        q_mag  = abs_a / safe_b;
        r_mag  = abs_a % safe_b;
        quot   = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem    = a_neg ? (~r_mag + 32'd1) : r_mag;

        res = '0;
        if ((md_op_E == MdMult) || (md_op_E == MdMultu)) begin
            res = prod;
        end else if (is_md_div(md_op_E)) begin
            // A zero divisor commits the current HI/LO back, leaving them unchanged.
            res = div_zero ? {hi_q, lo_q} : {rem, quot};
        end
    end

    assign start = is_md_start(md_op_E) && !busy_q;
    assign busy  = busy_q;

    always_comb begin
        md_rdata_E = 32'd0;
        if (md_op_E == MdMfhi) begin
            md_rdata_E = hi_q;
        end else if (md_op_E == MdMflo) begin
            md_rdata_E = lo_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            busy_q    <= 1'b0;
            cnt_q     <= 4'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        pend_hi_q <= res.hi;
                        pend_lo_q <= res.lo;
                        cnt_q     <= is_md_div(md_op_E) ? DIV_CNT : MULT_CNT;
                        busy_q    <= 1'b1;
                        state_q   <= StBusy;
                    end else if (md_op_E == MdMthi) begin
                        hi_q <= RD1_E;
                    end else if (md_op_E == MdMtlo) begin
                        lo_q <= RD1_E;
                    end
                end
                StBusy: begin
                    if (cnt_q == 4'd1) begin
                        hi_q    <= pend_hi_q;
                        lo_q    <= pend_lo_q;
                        cnt_q   <= 4'd0;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    cnt_q   <= 4'd0;
                end
            endcase
        end
    end

`ifdef MD_DIV0_FLAG_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div0_sticky <= 1'b0;
        end else if (start && is_md_div(md_op_E) && div_zero) begin
            div0_sticky <= 1'b1;
        end
    end
`endif

endmodule
